// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array operand buffer.
// Build option SA_SKEW_EN selects the diagonally skewed feed (2N-1 beats).
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } sa_state_e;

  function automatic int sa_beat_count(input int n);
`ifdef SA_SKEW_EN
    return (2 * n) - 1;
`else
    return n;
`endif
  endfunction

  function automatic int sa_lane_lsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/sa_col_select.sv
// Combinational beat selector: builds one col_out word from memory and beat index.
// With SA_SKEW_EN, lane r sees mem[r][k-r] inside the diagonal window, zero outside.
module sa_col_select
  import sa_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 8,
  localparam int CW = $clog2(N),
  localparam int BW = $clog2(2 * N)
) (
  input  logic [N-1:0][N-1:0][DW-1:0] mem_i,
  input  logic [BW-1:0]               beat_i,
  output logic [N*DW-1:0]             col_o
);

`ifdef SA_SKEW_EN
  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [BW-1:0] diff_s;
    logic [DW-1:0] lane_s;

    assign diff_s = beat_i - BW'(r);

    // Lane is live only while the beat lies inside this row's diagonal window
    always_comb begin
      lane_s = '0;
      if ((beat_i >= BW'(r)) && (diff_s < BW'(N))) begin
        lane_s = mem_i[r][CW'(diff_s)];
      end else begin
        lane_s = '0;
      end
    end

    assign col_o[sa_lane_lsb(r, DW) +: DW] = lane_s;
  end
`else
  logic unused_beat_msb_s;
  assign unused_beat_msb_s = beat_i[BW-1];

  for (genvar r = 0; r < N; r++) begin : g_lane
    assign col_o[sa_lane_lsb(r, DW) +: DW] = mem_i[r][beat_i[CW-1:0]];
  end
`endif

endmodule

// File: rtl/sa_operand_buf.sv
// N x N operand buffer: element-wise fill, then column stream over valid/ready.
// Define SA_SKEW_EN for the diagonally skewed 2N-1 beat sequence.
module sa_operand_buf
  import sa_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int DW = 8,
  localparam int AW = $clog2(N * N),
  localparam int BW = $clog2(2 * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              clear,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*DW-1:0]   col_out,
  output logic [BW-1:0]     beat_idx
);

  localparam int            CW        = AW / 2;
  localparam int            BEATS     = sa_beat_count(N);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  sa_state_e                     state_q, state_d;
  logic [N-1:0][N-1:0][DW-1:0]   mem_q, mem_d;
  logic [BW-1:0]                 beat_q, beat_d;
  logic [N*DW-1:0]               col_q, col_d;
  logic                          valid_q, busy_q, done_q;

  logic [CW-1:0]                 wrow_s, wcol_s;
  logic [BW-1:0]                 sel_beat_s;
  logic [N*DW-1:0]               sel_col_s;

  assign wrow_s = waddr[AW-1:CW];
  assign wcol_s = waddr[CW-1:0];

  // The selector always looks one beat ahead so the next word is ready at accept.
  assign sel_beat_s = (state_q == STREAM) ? (beat_q + BW'(1'b1)) : '0;

  sa_col_select #(
    .N  (N),
    .DW (DW)
  ) u_col_select (
    .mem_i  (mem_q),
    .beat_i (sel_beat_s),
    .col_o  (sel_col_s)
  );

  // Next-state, memory update and beat sequencing
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    beat_d  = beat_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          mem_d = '0;
        end else if (we) begin
          mem_d[wrow_s][wcol_s] = wdata;
        end else begin
          mem_d = mem_q;
        end
        if (start) begin
          state_d = STREAM;
          beat_d  = '0;
          col_d   = sel_col_s;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = FIN;
            beat_d  = '0;
            col_d   = '0;
          end else begin
            beat_d = beat_q + BW'(1'b1);
            col_d  = sel_col_s;
          end
        end else begin
          state_d = STREAM;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
        col_d   = '0;
      end
    endcase
  end

  // State, memory and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mem_q   <= '0;
      beat_q  <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      beat_q  <= beat_d;
      col_q   <= col_d;
      valid_q <= (state_d == STREAM);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == FIN);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign col_out   = col_q;
  assign beat_idx  = beat_q;

endmodule

// File: tb/tb_sa_operand_buf.sv
// Self-checking bench for sa_operand_buf: queue-based reference model plus literal checks.
// Honours SA_SKEW_EN the same way as the design.
`timescale 1ns/1ps
module tb_sa_operand_buf;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = $clog2(N * N);
  localparam int BW = $clog2(2 * N);
  localparam int HW = AW / 2;
`ifdef SA_SKEW_EN
  localparam int BEATS = 2 * N - 1;
`else
  localparam int BEATS = N;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              we = 1'b0;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic              out_ready = 1'b0;
  logic [AW-1:0]     waddr = '0;
  logic [DW-1:0]     wdata = '0;
  logic              busy, done, out_valid;
  logic [N*DW-1:0]   col_out;
  logic [BW-1:0]     beat_idx;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0]     mem_m [N][N];
  logic [N*DW-1:0]   q_m [$];
  bit                done_m   = 1'b0;
  bit                model_on = 1'b0;
  logic [N*DW-1:0]   cap [2*N];
  int                lat;

  always #5 clk = ~clk;

  sa_operand_buf #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .clear     (clear),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .col_out   (col_out),
    .beat_idx  (beat_idx)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] model_beat(input int k);
    logic [N*DW-1:0] v = '0;
    for (int r = 0; r < N; r++) begin
`ifdef SA_SKEW_EN
      int c = k - r;
`else
      int c = k;
`endif
      if (c >= 0 && c < N) v[r*DW +: DW] = mem_m[r][c];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mem_m[r][c] = '0;
    q_m.delete();
    done_m = 1'b0;
  endtask

  // Reference model advances on each edge; outputs are compared shortly after.
  always @(posedge clk) begin
    if (reset && model_on) begin
      if (q_m.size() != 0) begin
        if (out_ready) begin
          void'(q_m.pop_front());
          if (q_m.size() == 0) done_m = 1'b1;
        end
      end else if (done_m) begin
        done_m = 1'b0;
      end else begin
        if (clear) begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mem_m[r][c] = '0;
        end else if (we) begin
          mem_m[int'(waddr[AW-1:HW])][int'(waddr[HW-1:0])] = wdata;
        end
        if (start) begin
          for (int k = 0; k < BEATS; k++) q_m.push_back(model_beat(k));
        end
      end
    end
    #2;
    if (model_on) begin
      chk("out_valid", 64'(out_valid), 64'(q_m.size() != 0));
      chk("busy", 64'(busy), 64'((q_m.size() != 0) || done_m));
      chk("done", 64'(done), 64'(done_m));
      if (q_m.size() != 0) begin
        chk("col_out", 64'(col_out), 64'(q_m[0]));
        chk("beat_idx", 64'(beat_idx), 64'(BEATS - q_m.size()));
      end
    end
  end

  task automatic wr(input int r, input int c, input logic [DW-1:0] d, input bit clr);
    logic [HW-1:0] rs, cs;
    rs = HW'(r);
    cs = HW'(c);
    we = 1'b1; waddr = {rs, cs}; wdata = d; clear = clr;
    @(posedge clk); #3;
    we = 1'b0; clear = 1'b0;
  endtask

  task automatic stream(input int mode, input bit disturb, output int l);
    bit seen = 1'b0;
    l = 0;
    for (int i = 0; i < 2 * N; i++) cap[i] = '0;
    start = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (i % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (disturb && i == 2) begin
        we = 1'b1; waddr = '0; wdata = 8'hFF; clear = 1'b1; start = 1'b1;
      end else if (i > 0) begin
        we = 1'b0; clear = 1'b0; start = 1'b0;
      end
      @(posedge clk); #3;
      if (out_valid) cap[beat_idx] = col_out;
      if (done) begin
        seen = 1'b1;
        l = i + 1;
      end
    end
    start = 1'b0; we = 1'b0; clear = 1'b0;
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #3;
  endtask

  initial begin
    #1 reset = 1'b0;
    model_reset();
    model_on = 1'b1;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #3;

    // Empty buffer streams zeros; done lands beats+1 cycles after start.
    stream(0, 1'b0, lat);
    chk("latency", 64'(lat), 64'(BEATS + 1));
    chk("busy_after", 64'(busy), 64'd0);
    chk("zero_beat0", 64'(cap[0]), 64'd0);

    // Known fill pattern.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wr(r, c, DW'(16 * r + c), 1'b0);
    stream(0, 1'b0, lat);
`ifdef SA_SKEW_EN
    chk("skew_beat0", 64'(cap[0]), 64'h0000_0000);
    chk("skew_beat3", 64'(cap[3]), 64'h3021_1203);
    chk("skew_beat6", 64'(cap[6]), 64'h3300_0000);
`else
    chk("beat1_lit", 64'(cap[1]), 64'h3121_1101);
    chk("beat3_lit", 64'(cap[3]), 64'h3323_1303);
`endif

    // Stalls with ready pattern 1,0,0,1,...
    stream(1, 1'b0, lat);
    chk("stall_beat3", 64'(cap[3]), 64'(model_beat(3)));

    // we/clear/start while busy must be ignored.
    stream(0, 1'b1, lat);
    chk("disturb_lat", 64'(lat), 64'(BEATS + 1));
    stream(0, 1'b0, lat);
    chk("mem00_kept", 64'(cap[0][DW-1:0]), 64'h00);
`ifndef SA_SKEW_EN
    chk("beat1_kept", 64'(cap[1]), 64'h3121_1101);
`endif

    // Asynchronous reset in the middle of a stream.
    begin
      bit found = 1'b0;
      start = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 20 && !found; i++) begin
        @(posedge clk); #3;
        start = 1'b0;
        if (out_valid && beat_idx == BW'(2)) found = 1'b1;
      end
      if (!found) chk("beat2_timeout", 64'd0, 64'd1);
    end
    #1 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_col_out", 64'(col_out), 64'd0);
    chk("rst_beat_idx", 64'(beat_idx), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #3;
    stream(0, 1'b0, lat);
    chk("post_rst_beat1", 64'(cap[1]), 64'd0);
    chk("post_rst_last", 64'(cap[BEATS-1]), 64'd0);

    // Randomised fills (occasional clear, sometimes with we) and random ready.
    for (int it = 0; it < 8; it++) begin
      int nw = int'($urandom_range(1, 12));
      for (int j = 0; j < nw; j++)
        wr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
           DW'($urandom), ($urandom_range(0, 7) == 0));
      stream(2, 1'b0, lat);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
